reg_ctx_mover: RTL and testbench
================================

# reg_ctx_mover

Context save/restore engine for the CPU register file. On request it copies registers 0..NREGS-1 of the currently selected bank/scratch space out to memory (save) or from memory back into the register file (restore). It sits beside the register file: it drives the poke read port and the single write port, and acts as a memory-bus initiator. Trap entry/exit and bank-switch code use it to spill or fill a context without CPU instruction overhead.

## Interface
Parameters:
- NREGS, 8, number of registers moved, addresses 0..NREGS-1; legal range 1..12, so IRA/SP/SR/PC are never written.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- dir  in  1  0 = save (regs -> mem), 1 = restore (mem -> regs); sampled with start.
- mem_base  in  16  word address of slot 0; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- reg_rd_addr  out  4  to the register poke read address.
- reg_rd_data  in  16  from the register poke read data; combinational on reg_rd_addr.
- reg_wr_addr  out  4  register write address.
- reg_wr_data  out  16  register write data.
- reg_wr_en  out  1  register write strobe.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  16  word address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  transfer complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  read data.

## Operation
- Internal state: base (16), idx (4), dir (1), data (16).
- FSM states: IDLE, SAVE_RD, SAVE_REQ, LOAD_REQ, LOAD_WB, DONE.
- IDLE or DONE with start=1:
  - Latch base, dir and idx=0.
  - Go to SAVE_RD if dir=0, otherwise LOAD_REQ.
  - start is ignored in every other state.
- SAVE_RD:
  - reg_rd_addr=idx.
  - data <= reg_rd_data.
  - Go to SAVE_REQ.
- SAVE_REQ:
  - mem_req=1, mem_we=1, mem_addr=base+idx, mem_wdata=data.
  - Hold all values until mem_ack=1.
  - On ack, if idx=NREGS-1 go to DONE, otherwise idx++ and go to SAVE_RD.
- LOAD_REQ:
  - mem_req=1, mem_we=0, mem_addr=base+idx.
  - On ack, data <= mem_rdata and go to LOAD_WB.
- LOAD_WB:
  - reg_wr_en=1 for exactly one cycle, reg_wr_addr=idx, reg_wr_data=data.
  - If idx=NREGS-1 go to DONE, otherwise idx++ and go to LOAD_REQ.
- DONE: done=1 and busy=0 for one cycle, then IDLE, unless start is accepted in that cycle.
- busy=1 in SAVE_RD, SAVE_REQ, LOAD_REQ and LOAD_WB.
- Address arithmetic is 16-bit modulo: base+idx wraps 0xFFFF -> 0x0000 with no error.
- Bank selection (SR[15:8]) is owned by the register file. Software must not change SR while busy; this block does not check it.
- Outputs when not active:
  - mem_req=0, mem_we=0, reg_wr_en=0.
  - mem_addr, mem_wdata, reg_wr_addr, reg_wr_data and reg_rd_addr hold 0 in IDLE.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset (reset_n=0) is asynchronous: state=IDLE and every output is 0 (busy, done, mem_req, mem_we, reg_wr_en, all address/data buses).
- Reset mid-operation:
  - mem_req and reg_wr_en drop immediately.
  - No further register or memory writes occur.
  - A partially moved context is left as is.
- Per word:
  - Save costs 1 + W cycles; restore costs W + 1 cycles.
  - W is the number of mem_req cycles up to and including the ack cycle (W=1 with mem_ack tied high).
- With ack tied high and NREGS=8, start is sampled at edge 0, the first transfer occurs in cycle 1, the last transfer in cycle 16, and done=1 in cycle 17.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable for the whole request, including wait cycles.
- Back-to-back: start in the DONE cycle begins the new operation at the next edge with no IDLE cycle.

## Test plan
- Save, ack tied high, NREGS=8, base=0x0100, regs r0..r7=0xA000..0xA007:
  - Memory writes go to 0x0100..0x0107 with matching data.
  - done occurs in cycle 17.
  - reg_wr_en never asserts.
- Restore, base=0x0200, mem 0x0200..0x0207=0x5A00..0x5A07, ack delayed 3 cycles per request:
  - Eight single-cycle reg_wr_en pulses, addr 0..7, data 0x5A00..0x5A07.
  - mem_addr is stable during each wait.
- Wrap-around, base=0xFFFE, save:
  - Addresses are 0xFFFE, 0xFFFF, 0x0000..0x0005.
- start pulsed while busy, with different dir/base:
  - It is ignored and the original operation completes unchanged.
  - start asserted in the DONE cycle launches the next operation with no gap.
- reset_n low during the 4th restore request's wait:
  - mem_req and busy go to 0 asynchronously.
  - No further reg_wr_en pulses occur.
  - A fresh start after release works normally.
- NREGS=12, restore:
  - Writes cover addresses 0x0..0xB only.
  - reg_wr_addr never reaches 0xC..0xF.

Source files
------------

// File: rtl/reg_ctx_mover_if.sv
// Handshake and bus bundle for the register-context save/restore engine.
// The master modport is the engine; the slave modport is the register file/memory side.
interface reg_ctx_mover_if;
    logic        start;
    logic        dir;
    logic [15:0] mem_base;
    logic        busy;
    logic        done;
    logic [3:0]  reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic [3:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_en;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        input  start, dir, mem_base, reg_rd_data, mem_ack, mem_rdata,
        output busy, done, reg_rd_addr, reg_wr_addr, reg_wr_data, reg_wr_en,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, dir, mem_base, reg_rd_data, mem_ack, mem_rdata,
        input  busy, done, reg_rd_addr, reg_wr_addr, reg_wr_data, reg_wr_en,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/reg_ctx_mover.sv
// Copies registers 0..NREGS-1 to memory (save) or from memory (restore).
// Every output is a flop computed from next-state, so buses stay stable through ack waits.
module reg_ctx_mover #(
    parameter int unsigned NREGS = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    reg_ctx_mover_if.master  bus_io
);

    localparam logic [3:0] LastIdx = 4'(NREGS - 1);

    typedef enum logic [2:0] {
        StIdle, StSaveRd, StSaveReq, StLoadReq, StLoadWb, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] data_q, data_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  reg_rd_addr_q, reg_rd_addr_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic [3:0]  reg_wr_addr_q, reg_wr_addr_d;
    logic [15:0] reg_wr_data_q, reg_wr_data_d;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        data_d  = data_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus_io.start) begin
                    base_d  = bus_io.mem_base;
                    idx_d   = 4'd0;
                    state_d = bus_io.dir ? StLoadReq : StSaveRd;
                end
            end
            StSaveRd: begin
                data_d  = bus_io.reg_rd_data;
                state_d = StSaveReq;
            end
            StSaveReq: begin
                if (bus_io.mem_ack) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StSaveRd;
                    end
                end
            end
            StLoadReq: begin
                if (bus_io.mem_ack) begin
                    data_d  = bus_io.mem_rdata;
                    state_d = StLoadWb;
                end
            end
            StLoadWb: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StLoadReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output image of the state being entered; registered below.
    always_comb begin
        busy_d        = 1'b0;
        done_d        = 1'b0;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = 16'h0000;
        mem_wdata_d   = 16'h0000;
        reg_rd_addr_d = 4'h0;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = 4'h0;
        reg_wr_data_d = 16'h0000;

        unique case (state_d)
            StSaveRd: begin
                busy_d        = 1'b1;
                reg_rd_addr_d = idx_d;
            end
            StSaveReq: begin
                busy_d      = 1'b1;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = base_d + {12'h000, idx_d};
                mem_wdata_d = data_d;
            end
            StLoadReq: begin
                busy_d     = 1'b1;
                mem_req_d  = 1'b1;
                mem_addr_d = base_d + {12'h000, idx_d};
            end
            StLoadWb: begin
                busy_d        = 1'b1;
                reg_wr_en_d   = 1'b1;
                reg_wr_addr_d = idx_d;
                reg_wr_data_d = data_d;
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            base_q        <= 16'h0000;
            idx_q         <= 4'h0;
            data_q        <= 16'h0000;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 16'h0000;
            mem_wdata_q   <= 16'h0000;
            reg_rd_addr_q <= 4'h0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= 4'h0;
            reg_wr_data_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            reg_rd_addr_q <= reg_rd_addr_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
        end
    end

    assign bus_io.busy        = busy_q;
    assign bus_io.done        = done_q;
    assign bus_io.mem_req     = mem_req_q;
    assign bus_io.mem_we      = mem_we_q;
    assign bus_io.mem_addr    = mem_addr_q;
    assign bus_io.mem_wdata   = mem_wdata_q;
    assign bus_io.reg_rd_addr = reg_rd_addr_q;
    assign bus_io.reg_wr_en   = reg_wr_en_q;
    assign bus_io.reg_wr_addr = reg_wr_addr_q;
    assign bus_io.reg_wr_data = reg_wr_data_q;

endmodule

// File: tb/tb_reg_ctx_mover.sv
// Directed bench for reg_ctx_mover: an 8-register and a 12-register instance
// with a register-file model, a fixed-content memory and a delayed-ack responder.
module tb_reg_ctx_mover;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_ctx_mover_if b8 ();
    reg_ctx_mover_if b12 ();

    reg_ctx_mover #(.NREGS(8)) u_dut8 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (b8.master)
    );

    reg_ctx_mover #(.NREGS(12)) u_dut12 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (b12.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory content is a fixed function of address; saves only go to the write log.
    function automatic logic [15:0] init_mem(input logic [15:0] a);
        case (a[15:8])
            8'h02:   return {8'h5A, a[7:0]};
            8'h05:   return {8'h11, a[7:0]};
            8'h06:   return {8'h77, a[7:0]};
            8'h08:   return {8'h3C, a[7:0]};
            default: return 16'h0000;
        endcase
    endfunction

    logic        rf_init;
    int          ack_delay;
    int          wcnt = 0;
    logic [15:0] rf8 [16];
    logic [15:0] rf12 [16];
    logic [15:0] mw_addr [256];
    logic [15:0] mw_data [256];
    logic [3:0]  wr_addr [256];
    logic [15:0] wr_data [256];
    int          nmw = 0, nwr = 0, nlong = 0, nunst = 0, nwr12 = 0, nhi = 0;
    logic        wr_prev = 1'b0, pend = 1'b0;
    logic [32:0] prev_req = '0;

    assign b8.reg_rd_data  = rf8[b8.reg_rd_addr];
    assign b8.mem_ack      = b8.mem_req && (wcnt >= ack_delay);
    assign b8.mem_rdata    = init_mem(b8.mem_addr);
    assign b12.reg_rd_data = rf12[b12.reg_rd_addr];
    assign b12.mem_ack     = b12.mem_req;
    assign b12.mem_rdata   = init_mem(b12.mem_addr);

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) begin
                rf8[i]  <= 16'hA000 + 16'(i);
                rf12[i] <= 16'h0000;
            end
        end
        wcnt <= (b8.mem_req && !b8.mem_ack) ? wcnt + 1 : 0;
        if (b8.mem_req && b8.mem_we && b8.mem_ack) begin
            mw_addr[nmw[7:0]] <= b8.mem_addr;
            mw_data[nmw[7:0]] <= b8.mem_wdata;
            nmw <= nmw + 1;
        end
        if (b8.reg_wr_en) begin
            rf8[b8.reg_wr_addr] <= b8.reg_wr_data;
            wr_addr[nwr[7:0]]   <= b8.reg_wr_addr;
            wr_data[nwr[7:0]]   <= b8.reg_wr_data;
            nwr <= nwr + 1;
        end
        if (b8.reg_wr_en && wr_prev) nlong <= nlong + 1;
        wr_prev <= b8.reg_wr_en;
        // Request fields must not move while a request is waiting for ack.
        if (pend && b8.mem_req && ({b8.mem_we, b8.mem_addr, b8.mem_wdata} != prev_req))
            nunst <= nunst + 1;
        pend     <= b8.mem_req && !b8.mem_ack;
        prev_req <= {b8.mem_we, b8.mem_addr, b8.mem_wdata};
        if (b12.reg_wr_en) begin
            rf12[b12.reg_wr_addr] <= b12.reg_wr_data;
            nwr12 <= nwr12 + 1;
            if (b12.reg_wr_addr >= 4'hC) nhi <= nhi + 1;
        end
    end

    task automatic go(input bit use12, input logic d, input logic [15:0] base);
        @(negedge clk);
        if (use12) begin
            b12.start = 1'b1; b12.dir = d; b12.mem_base = base;
        end else begin
            b8.start = 1'b1; b8.dir = d; b8.mem_base = base;
        end
        @(posedge clk);
        #1;
        b8.start  = 1'b0;
        b12.start = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the edge that accepted start.
    task automatic wait_done(input bit use12, input string tag, input int exp_cyc);
        int cyc  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            seen = use12 ? b12.done : b8.done;
        end
        if (!seen) begin
            check({tag, " timeout"}, 64'(0), 64'(1));
        end else begin
            check({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
            check({tag, " busy in done"}, 64'(use12 ? b12.busy : b8.busy), 64'(0));
        end
    endtask

    initial begin
        int s, w;
        bit found;
        rst_n = 1'b0;
        rf_init = 1'b1;
        ack_delay = 0;
        b8.start = 1'b0;  b8.dir = 1'b0;  b8.mem_base = 16'h0000;
        b12.start = 1'b0; b12.dir = 1'b0; b12.mem_base = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset outputs", 64'({b8.busy, b8.done, b8.mem_req, b8.mem_we, b8.reg_wr_en,
              b8.mem_addr, b8.mem_wdata, b8.reg_wr_addr, b8.reg_wr_data, b8.reg_rd_addr}),
              64'(0));
        check("reset busy12", 64'(b12.busy), 64'(0));
        rf_init = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // Save, ack tied high.
        s = nmw; w = nwr;
        go(1'b0, 1'b0, 16'h0100);
        wait_done(1'b0, "save", 17);
        check("save writes", 64'(nmw - s), 64'(8));
        for (int i = 0; i < 8; i++) begin
            check("save addr", 64'(mw_addr[8'(s + i)]), 64'(16'h0100 + 16'(i)));
            check("save data", 64'(mw_data[8'(s + i)]), 64'(16'hA000 + 16'(i)));
        end
        check("save no reg wr", 64'(nwr - w), 64'(0));
        @(negedge clk);
        check("idle after done", 64'({b8.done, b8.busy, b8.mem_addr}), 64'(0));

        // Restore with 3 wait cycles per request.
        ack_delay = 3;
        s = nwr;
        go(1'b0, 1'b1, 16'h0200);
        wait_done(1'b0, "restore", 41);
        check("restore writes", 64'(nwr - s), 64'(8));
        for (int i = 0; i < 8; i++) begin
            check("restore waddr", 64'(wr_addr[8'(s + i)]), 64'(i));
            check("restore wdata", 64'(wr_data[8'(s + i)]), 64'(16'h5A00 + 16'(i)));
        end
        check("rf8[7] restored", 64'(rf8[7]), 64'(16'h5A07));
        ack_delay = 0;

        // Address wrap.
        s = nmw;
        go(1'b0, 1'b0, 16'hFFFE);
        wait_done(1'b0, "wrap", 17);
        check("wrap a0", 64'(mw_addr[8'(s)]), 64'(16'hFFFE));
        check("wrap a1", 64'(mw_addr[8'(s + 1)]), 64'(16'hFFFF));
        check("wrap a2", 64'(mw_addr[8'(s + 2)]), 64'(16'h0000));
        check("wrap a7", 64'(mw_addr[8'(s + 7)]), 64'(16'h0005));
        check("wrap d7", 64'(mw_data[8'(s + 7)]), 64'(16'h5A07));

        // start while busy is ignored; start in done cycle chains with no gap.
        s = nmw; w = nwr;
        go(1'b0, 1'b0, 16'h0300);
        repeat (3) @(posedge clk);
        #1;
        b8.start = 1'b1; b8.dir = 1'b1; b8.mem_base = 16'h0400;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        wait_done(1'b0, "busy start", 13);
        check("ignored writes", 64'(nmw - s), 64'(8));
        check("ignored a7", 64'(mw_addr[8'(s + 7)]), 64'(16'h0307));
        check("ignored d7", 64'(mw_data[8'(s + 7)]), 64'(16'h5A07));
        check("ignored no reg wr", 64'(nwr - w), 64'(0));
        b8.start = 1'b1; b8.dir = 1'b1; b8.mem_base = 16'h0500;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        @(negedge clk);
        check("chain first cycle", 64'({b8.busy, b8.mem_req, b8.mem_we, b8.mem_addr}),
              64'({1'b1, 1'b1, 1'b0, 16'h0500}));
        wait_done(1'b0, "chain", 16);
        check("chain rf8[7]", 64'(rf8[7]), 64'(16'h1107));

        // Reset during the 4th restore request's wait.
        ack_delay = 3;
        w = nwr;
        found = 1'b0;
        go(1'b0, 1'b1, 16'h0600);
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = b8.mem_req && (b8.mem_addr == 16'h0603) && !b8.mem_ack;
        end
        check("reached 4th req", 64'(found), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async drop", 64'({b8.mem_req, b8.busy, b8.reg_wr_en}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("partial writes", 64'(nwr - w), 64'(3));
        check("partial rf8[2]", 64'(rf8[2]), 64'(16'h7702));
        check("partial rf8[3]", 64'(rf8[3]), 64'(16'h1103));
        ack_delay = 0;
        s = nmw;
        go(1'b0, 1'b0, 16'h0700);
        wait_done(1'b0, "post reset", 17);
        check("post reset a0", 64'(mw_addr[8'(s)]), 64'(16'h0700));
        check("post reset d0", 64'(mw_data[8'(s)]), 64'(16'h7700));
        check("post reset d3", 64'(mw_data[8'(s + 3)]), 64'(16'h1103));

        // NREGS=12 restore.
        go(1'b1, 1'b1, 16'h0800);
        wait_done(1'b1, "n12", 25);
        check("n12 writes", 64'(nwr12), 64'(12));
        check("n12 high addr", 64'(nhi), 64'(0));
        check("n12 rf[11]", 64'(rf12[11]), 64'(16'h3C0B));
        check("n12 rf[12]", 64'(rf12[12]), 64'(16'h0000));

        check("wr pulse width", 64'(nlong), 64'(0));
        check("req stability", 64'(nunst), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
